wb_merge_buffer: RTL and testbench
==================================

// Module: wb_merge_buffer
// PURPOSE
//  Writeback merge stage between the two execute lanes and the single-write-port register file.
//  Takes up to two results per cycle and buffers them in order in a small FIFO.
//  Drains one result per cycle onto the register file write port (WE3/WA3/WD3).
//  A lookup port returns the youngest pending value for a register, so decode can forward it.
// PARAMETERS
//  DEPTH  4   FIFO entries; power of 2, >=4
//  AW     5   register address width
//  DW     32  register data width
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  l0_valid  in   1          lane0 result valid (older instruction)
//  l0_rd     in   AW         lane0 destination register
//  l0_data   in   DW         lane0 result
//  l1_valid  in   1          lane1 result valid (younger instruction)
//  l1_rd     in   AW         lane1 destination register
//  l1_data   in   DW         lane1 result
//  in_ready  out  1          buffer can accept two results this cycle
//  WE3       out  1          register file write enable
//  WA3       out  AW         register file write address
//  WD3       out  DW         register file write data
//  lk_addr   in   AW         forwarding lookup address
//  lk_hit    out  1          a pending entry exists for lk_addr
//  lk_data   out  DW         youngest pending data for lk_addr
//  count     out  log2(DEPTH)+1  occupancy
//  ovf_err   out  1          sticky: valid input offered while in_ready=0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - Clears rd/wr pointers, count and ovf_err.
//   - WE3=0, lk_hit=0, in_ready=1 immediately. WA3/WD3 are don't-care.
//  in_ready = (count <= DEPTH-2), taken from registered count. It is not a function of this cycle's inputs.
//  Accept filter, applied at the edge when in_ready=1:
//   - Lane with rd==0 is dropped (x0 never written).
//   - l0 and l1 both valid, same nonzero rd: l0 dropped, only l1 enqueued (younger wins).
//   - Survivors enqueued lane0 first, then lane1. 0, 1 or 2 entries per cycle.
//  When in_ready=0: inputs are ignored; any lN_valid sets ovf_err (cleared only by reset).
//  Drain:
//   - WE3 = (count!=0), combinational from registered state.
//   - WA3/WD3 = head entry. Head pops at each edge where count!=0.
//   - The register file is written at that same edge.
//  Latency:
//   - Entry enqueued at edge N is presented on WA3/WD3 in cycle N+1 if the FIFO was empty.
//   - It is written to the register file at edge N+1. There is no same-cycle bypass.
//  Simultaneous operations in one cycle:
//   - push2+pop: count+1.
//   - push1+pop: count unchanged.
//   - push0+pop: count-1.
//  Pointers wrap modulo DEPTH. Count never exceeds DEPTH and never underflows.
//  Lookup (combinational over stored entries only, not this cycle's inputs):
//   - lk_hit=1 if any valid entry has rd==lk_addr. lk_data is the youngest such entry.
//   - The head entry counts as pending in the cycle it is being written.
//   - lk_addr==0 -> lk_hit=0, lk_data=0. No match -> lk_data=0.
//  Reset mid-operation: all pending entries are discarded, with no partial write. WE3 falls asynchronously.
// TESTING
//  T1:
//   - Stimulus: l0 {rd=3, data=0x11} alone, FIFO empty.
//   - Response: next cycle WE3=1, WA3=3, WD3=0x11. Following cycle WE3=0.
//  T2:
//   - Stimulus: l0 {5, 0xA}, l1 {5, 0xB} same cycle.
//   - Response: one entry only, count=1. WA3=5, WD3=0xB.
//  T3:
//   - Stimulus: l0 {0, 0xFF}, l1 {7, 0x22}.
//   - Response: one entry, WA3=7. x0 is never written.
//  T4:
//   - Stimulus: 3 consecutive cycles of two-lane pushes to distinct rd (DEPTH=4).
//   - Response: count goes 0->2->3. in_ready=0 at count 3.
//   - Third push ignored, ovf_err=1. Entries drain in lane0/lane1 program order.
//  T5:
//   - Stimulus: enqueue rd=9 with 0x1, then rd=9 with 0x2. Set lk_addr=9.
//   - Response: lk_hit=1, lk_data=0x2. Once both entries have drained, lk_hit=0.
//  T6:
//   - Stimulus: rst_n low with count=3.
//   - Response: WE3=0, count=0, ovf_err=0 immediately (before next clock). No stale writes after release.

Source files
------------

// File: rtl/wb_merge_buffer.sv
// Writeback merge FIFO: accepts up to two lane results per cycle, drains one per
// cycle onto the register file write port, and forwards the youngest pending value.
module wb_merge_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     l0_valid,
  input  logic [AW-1:0]            l0_rd,
  input  logic [DW-1:0]            l0_data,
  input  logic                     l1_valid,
  input  logic [AW-1:0]            l1_rd,
  input  logic [DW-1:0]            l1_data,
  output logic                     in_ready,
  output logic                     WE3,
  output logic [AW-1:0]            WA3,
  output logic [DW-1:0]            WD3,
  input  logic [AW-1:0]            lk_addr,
  output logic                     lk_hit,
  output logic [DW-1:0]            lk_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [PW-1:0] wr_ptr_next, wr_ptr_inc;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_err_reg;

  logic [AW-1:0] rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic          keep0, keep1;
  logic          push0, push1, pop;
  logic [1:0]    push_cnt;
  logic [AW-1:0] slot0_rd;
  logic [DW-1:0] slot0_data;

  // x0 results vanish; when both lanes target the same register only the younger survives
  assign keep1 = l1_valid && (l1_rd != '0);
  assign keep0 = l0_valid && (l0_rd != '0) && !(keep1 && (l1_rd == l0_rd));

  assign in_ready = (count_reg <= CW'(DEPTH - 2));
  assign pop      = (count_reg != '0);

  assign push0    = in_ready && (keep0 || keep1);
  assign push1    = in_ready && keep0 && keep1;
  assign push_cnt = {1'b0, push0} + {1'b0, push1};

  assign slot0_rd   = keep0 ? l0_rd   : l1_rd;
  assign slot0_data = keep0 ? l0_data : l1_data;

  assign wr_ptr_inc  = wr_ptr_reg + PW'(1);
  assign wr_ptr_next = wr_ptr_reg + PW'(push_cnt);
  assign count_next  = count_reg + CW'(push_cnt) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      ovf_err_reg <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      if (!in_ready && (l0_valid || l1_valid)) begin
        ovf_err_reg <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; validity comes solely from the pointers and count
  always_ff @(posedge clk) begin
    if (push0) begin
      rd_mem[wr_ptr_reg]   <= slot0_rd;
      data_mem[wr_ptr_reg] <= slot0_data;
    end
    if (push1) begin
      rd_mem[wr_ptr_inc]   <= l1_rd;
      data_mem[wr_ptr_inc] <= l1_data;
    end
  end

  assign WE3     = pop;
  assign WA3     = rd_mem[rd_ptr_reg];
  assign WD3     = data_mem[rd_ptr_reg];
  assign count   = count_reg;
  assign ovf_err = ovf_err_reg;

  // Match vector indexed by age: slot gi is the gi-th oldest pending entry
  logic [PW-1:0]    slot_idx [DEPTH];
  logic [DEPTH-1:0] match;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign slot_idx[gi] = rd_ptr_reg + PW'(gi);
      assign match[gi]    = (CW'(gi) < count_reg) && (rd_mem[slot_idx[gi]] == lk_addr);
    end
  endgenerate

  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    if (lk_addr != '0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (match[k]) begin
          lk_hit  = 1'b1;
          lk_data = data_mem[slot_idx[k]];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_merge_buffer.sv
// Bench for wb_merge_buffer: directed vector table, reset corner case, and
// randomized traffic checked against a queue-based reference model.
module tb_wb_merge_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l0_valid, l1_valid;
  logic [AW-1:0] l0_rd, l1_rd, lk_addr;
  logic [DW-1:0] l0_data, l1_data;
  logic          in_ready, WE3, lk_hit, ovf_err;
  logic [AW-1:0] WA3;
  logic [DW-1:0] WD3, lk_data;
  logic [2:0]    count;

  wb_merge_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .l0_valid(l0_valid), .l0_rd(l0_rd), .l0_data(l0_data),
    .l1_valid(l1_valid), .l1_rd(l1_rd), .l1_data(l1_data),
    .in_ready(in_ready), .WE3(WE3), .WA3(WA3), .WD3(WD3),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  typedef struct {
    logic v0; logic [4:0] rd0; logic [31:0] d0;
    logic v1; logic [4:0] rd1; logic [31:0] d1;
    logic [4:0] lk;
    logic [2:0] e_cnt; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
    logic e_hit; logic [31:0] e_ld; logic e_rdy; logic e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v0, logic [4:0] rd0, logic [31:0] d0,
                              logic v1, logic [4:0] rd1, logic [31:0] d1, logic [4:0] lk,
                              logic [2:0] e_cnt, logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic e_hit, logic [31:0] e_ld, logic e_rdy, logic e_ovf);
    vec_t v;
    v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1; v.lk = lk;
    v.e_cnt = e_cnt; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    v.e_hit = e_hit; v.e_ld = e_ld; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic [4:0] lk);
    l0_valid = v0; l0_rd = rd0; l0_data = d0;
    l1_valid = v1; l1_rd = rd1; l1_data = d1;
    lk_addr  = lk;
  endtask

  // Reference model: pending results as an in-order queue, oldest at the front
  logic [4:0]  m_rd[$];
  logic [31:0] m_data[$];
  logic        m_ovf;

  task automatic model_lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != 0) begin
      for (int i = m_rd.size() - 1; i >= 0; i--) begin
        if (m_rd[i] == a) begin
          hit = 1'b1;
          d   = m_data[i];
          break;
        end
      end
    end
  endtask

  task automatic model_clock(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
    bit rdy;
    rdy = (m_rd.size() <= DEPTH - 2);
    if (m_rd.size() > 0) begin
      void'(m_rd.pop_front());
      void'(m_data.pop_front());
    end
    if (rdy) begin
      if (v0 && rd0 != 0 && !(v1 && rd1 == rd0)) begin
        m_rd.push_back(rd0);
        m_data.push_back(d0);
      end
      if (v1 && rd1 != 0) begin
        m_rd.push_back(rd1);
        m_data.push_back(d1);
      end
    end else if (v0 || v1) begin
      m_ovf = 1'b1;
    end
  endtask

  initial begin
    logic        e_hit;
    logic [31:0] e_ld;
    int          pct;

    drive(0, 0, 0, 0, 0, 0, 0);

    // Directed table; expectations are the state seen one edge after each row's inputs
    //            v0 rd0 d0         v1 rd1 d1        lk  cnt we wa  wd         hit ld         rdy ovf
    vecs.push_back(mk(1, 3, 32'h11, 0, 0,  0,        3,  1, 1, 3,  32'h11, 1, 32'h11, 1, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        3,  0, 0, 0,  0,      0, 0,      1, 0));
    vecs.push_back(mk(1, 5, 32'hA,  1, 5,  32'hB,    5,  1, 1, 5,  32'hB,  1, 32'hB,  1, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        5,  0, 0, 0,  0,      0, 0,      1, 0));
    vecs.push_back(mk(1, 0, 32'hFF, 1, 7,  32'h22,   0,  1, 1, 7,  32'h22, 0, 0,      1, 0));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        7,  0, 0, 0,  0,      0, 0,      1, 0));
    vecs.push_back(mk(1, 1, 32'hA1, 1, 2,  32'hA2,   2,  2, 1, 1,  32'hA1, 1, 32'hA2, 1, 0));
    vecs.push_back(mk(1, 4, 32'hA4, 1, 6,  32'hA6,   6,  3, 1, 2,  32'hA2, 1, 32'hA6, 0, 0));
    vecs.push_back(mk(1, 8, 32'hA8, 1, 10, 32'hAA,   8,  2, 1, 4,  32'hA4, 0, 0,      1, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        4,  1, 1, 6,  32'hA6, 0, 0,      1, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        0,  0, 0, 0,  0,      0, 0,      1, 1));
    vecs.push_back(mk(1, 11, 32'hB, 1, 9,  32'h1,    9,  2, 1, 11, 32'hB,  1, 32'h1,  1, 1));
    vecs.push_back(mk(1, 9, 32'h2,  0, 0,  0,        9,  2, 1, 9,  32'h1,  1, 32'h2,  1, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        9,  1, 1, 9,  32'h2,  1, 32'h2,  1, 1));
    vecs.push_back(mk(0, 0, 0,      0, 0,  0,        9,  0, 0, 0,  0,      0, 0,      1, 1));

    #12;
    chk("reset_we3", WE3, 0);
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_lk_hit", lk_hit, 0);
    chk("reset_ovf", ovf_err, 0);
    $display("reset: we=%b count=%0d in_ready=%b ovf=%b", WE3, count, in_ready, ovf_err);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1, vecs[i].lk);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_we3", i), WE3, vecs[i].e_we);
      if (vecs[i].e_we) begin
        chk($sformatf("vec%0d_wa3", i), WA3, vecs[i].e_wa);
        chk($sformatf("vec%0d_wd3", i), WD3, vecs[i].e_wd);
      end
      chk($sformatf("vec%0d_lk_hit", i), lk_hit, vecs[i].e_hit);
      chk($sformatf("vec%0d_lk_data", i), lk_data, vecs[i].e_ld);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_ovf", i), ovf_err, vecs[i].e_ovf);
      $display("vec %0d: l0=%b/%0d/%0h l1=%b/%0d/%0h lk=%0d -> count=%0d we=%b wa=%0d wd=%0h hit=%b ld=%0h rdy=%b ovf=%b",
               i, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1, vecs[i].lk,
               count, WE3, WA3, WD3, lk_hit, lk_data, in_ready, ovf_err);
    end

    // Fill to count=3, then pull reset between edges
    drive(1, 1, 32'h101, 1, 2, 32'h102, 3);
    @(posedge clk); #1;
    drive(1, 3, 32'h103, 1, 4, 32'h104, 3);
    @(posedge clk); #1;
    chk("rst_pre_count", count, 3);
    chk("rst_pre_in_ready", in_ready, 0);
    chk("rst_pre_lk_hit", lk_hit, 1);
    drive(0, 0, 0, 0, 0, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_we3", WE3, 0);
    chk("rst_async_count", count, 0);
    chk("rst_async_ovf", ovf_err, 0);
    chk("rst_async_in_ready", in_ready, 1);
    chk("rst_async_lk_hit", lk_hit, 0);
    $display("async reset: we=%b count=%0d ovf=%b", WE3, count, ovf_err);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_we3", c), WE3, 0);
      chk($sformatf("post_rst%0d_count", c), count, 0);
    end

    // Randomized traffic against the queue model; push density varies by phase
    m_rd.delete();
    m_data.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic v0, v1;
      logic [4:0] rd0, rd1, lk;
      logic [31:0] d0, d1;
      pct = (c < 130) ? 80 : ((c < 260) ? 35 : 60);
      v0  = ($urandom_range(0, 99) < pct);
      v1  = ($urandom_range(0, 99) < pct);
      rd0 = 5'($urandom_range(0, 7));
      rd1 = 5'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      lk  = 5'($urandom_range(0, 7));
      drive(v0, rd0, d0, v1, rd1, d1, lk);
      #1;
      model_lookup(lk, e_hit, e_ld);
      chk("rnd_count", count, m_rd.size());
      chk("rnd_in_ready", in_ready, (m_rd.size() <= DEPTH - 2));
      chk("rnd_we3", WE3, (m_rd.size() != 0));
      if (m_rd.size() != 0) begin
        chk("rnd_wa3", WA3, m_rd[0]);
        chk("rnd_wd3", WD3, m_data[0]);
      end
      chk("rnd_lk_hit", lk_hit, e_hit);
      chk("rnd_lk_data", lk_data, e_ld);
      chk("rnd_ovf", ovf_err, m_ovf);
      $display("rnd %0d: l0=%b/%0d l1=%b/%0d lk=%0d count=%0d we=%b wa=%0d hit=%b ovf=%b",
               c, v0, rd0, v1, rd1, lk, count, WE3, WA3, lk_hit, ovf_err);
      @(posedge clk);
      model_clock(v0, rd0, d0, v1, rd1, d1);
      #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
